// File: rtl/prog_loader.sv
// Program loader: streams a program into IRAM, pulses CPU start, waits for idle, then dumps DRAM.
// Define PROG_LOADER_TIMEOUT_EN to build the RUN watchdog that forces the dump after TIMEOUT cycles.
module prog_loader #(
    parameter int unsigned W_IDATA   = 16,
    parameter int unsigned W_DDATA   = 8,
    parameter int unsigned W_ADDR    = 8,
    parameter int unsigned DUMP_BASE = 0,
    parameter int unsigned DUMP_LEN  = 256,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               s_last,
    input  logic [W_IDATA-1:0] s_data,
    output logic               iram_write,
    output logic [W_ADDR-1:0]  iram_addr,
    output logic [W_IDATA-1:0] iram_din,
    output logic               start,
    input  logic               idle,
    output logic [W_ADDR-1:0]  dram_addr,
    input  logic [W_DDATA-1:0] dram_dout,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
    output logic [W_DDATA-1:0] m_data,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {StLoad, StStart, StRun, StDumpRd, StDumpOut, StDone} state_e;

    localparam logic [W_ADDR-1:0] LastLoadAddr = '1;
    localparam logic [W_ADDR-1:0] LastDumpIdx  = W_ADDR'(DUMP_LEN - 1);
    localparam logic [W_ADDR-1:0] DumpBase     = W_ADDR'(DUMP_BASE);

    state_e              state_q, state_d;
    logic [W_ADDR-1:0]   load_cnt_q, load_cnt_d;
    logic [W_ADDR-1:0]   dump_cnt_q, dump_cnt_d;
    logic [W_DDATA-1:0]  m_data_q, m_data_d;
    logic                err_q, err_d;
    logic                run_first_q, run_first_d;
    logic                rd_wait_q, rd_wait_d;
    logic                timeout_hit;

`ifdef PROG_LOADER_TIMEOUT_EN
    localparam int unsigned     WRun    = $clog2(TIMEOUT + 1);
    localparam logic [WRun-1:0] RunLast = WRun'(TIMEOUT - 1);

    logic [WRun-1:0] run_cnt_q, run_cnt_d;

    // Counts RUN cycles from 0 at entry; the last RUN cycle is the one where it holds TIMEOUT-1.
    always_comb begin
        run_cnt_d = '0;
        if (state_q == StRun) run_cnt_d = run_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) run_cnt_q <= '0;
        else     run_cnt_q <= run_cnt_d;
    end

    assign timeout_hit = (run_cnt_q == RunLast);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        dump_cnt_d  = dump_cnt_q;
        m_data_d    = m_data_q;
        err_d       = err_q;
        run_first_d = run_first_q;
        rd_wait_d   = rd_wait_q;
        s_ready     = 1'b0;
        iram_write  = 1'b0;
        start       = 1'b0;
        m_valid     = 1'b0;
        m_last      = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            StLoad: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    iram_write = 1'b1;
                    load_cnt_d = load_cnt_q + 1'b1;
                    if (s_last) begin
                        state_d = StStart;
                    end else if (load_cnt_q == LastLoadAddr) begin
                        err_d   = 1'b1;
                        state_d = StStart;
                    end
                end
            end
            StStart: begin
                start       = 1'b1;
                run_first_d = 1'b1;
                state_d     = StRun;
            end
            StRun: begin
                // The CPU may still report idle in the cycle right after start.
                run_first_d = 1'b0;
                if (!run_first_q && idle) begin
                    state_d = StDumpRd;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = StDumpRd;
                end
            end
            StDumpRd: begin
                rd_wait_d = ~rd_wait_q;
                if (rd_wait_q) begin
                    m_data_d = dram_dout;
                    state_d  = StDumpOut;
                end
            end
            StDumpOut: begin
                m_valid = 1'b1;
                m_last  = (dump_cnt_q == LastDumpIdx);
                if (m_ready) begin
                    if (dump_cnt_q == LastDumpIdx) begin
                        state_d = StDone;
                    end else begin
                        dump_cnt_d = dump_cnt_q + 1'b1;
                        state_d    = StDumpRd;
                    end
                end
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
                state_d = StLoad;
            end
        endcase

        // Nothing may be written or handshaken while reset is asserted.
        if (rst) begin
            s_ready    = 1'b0;
            iram_write = 1'b0;
            start      = 1'b0;
            m_valid    = 1'b0;
            m_last     = 1'b0;
            done       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StLoad;
            load_cnt_q  <= '0;
            dump_cnt_q  <= '0;
            m_data_q    <= '0;
            err_q       <= 1'b0;
            run_first_q <= 1'b0;
            rd_wait_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            dump_cnt_q  <= dump_cnt_d;
            m_data_q    <= m_data_d;
            err_q       <= err_d;
            run_first_q <= run_first_d;
            rd_wait_q   <= rd_wait_d;
        end
    end

    assign iram_addr = rst ? '0 : load_cnt_q;
    assign iram_din  = iram_write ? s_data : '0;
    assign dram_addr = rst ? '0 : DumpBase + dump_cnt_q;
    assign m_data    = rst ? '0 : m_data_q;
    assign err       = err_q & ~rst;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader (W_ADDR=4 so the overflow and DRAM wrap are reachable).
// Honours PROG_LOADER_TIMEOUT_EN the same way the design does.
module tb_prog_loader;

    localparam int unsigned WA   = 4;
    localparam int unsigned BASE = 14;
    localparam int unsigned LEN  = 4;
    localparam int unsigned TO   = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0, s_ready, s_last = 1'b0;
    logic [15:0]   s_data = '0;
    logic          iram_write;
    logic [WA-1:0] iram_addr;
    logic [15:0]   iram_din;
    logic          start, idle = 1'b0;
    logic [WA-1:0] dram_addr;
    logic [7:0]    dram_dout;
    logic          m_valid, m_ready = 1'b0, m_last;
    logic [7:0]    m_data;
    logic          done, err;

    logic [7:0]    dram [16];
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    // DRAM model: registered read, one cycle of latency.
    always @(posedge clk) dram_dout <= dram[dram_addr];

    prog_loader #(
        .W_IDATA  (16),
        .W_DDATA  (8),
        .W_ADDR   (WA),
        .DUMP_BASE(BASE),
        .DUMP_LEN (LEN),
        .TIMEOUT  (TO)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_last    (s_last),
        .s_data    (s_data),
        .iram_write(iram_write),
        .iram_addr (iram_addr),
        .iram_din  (iram_din),
        .start     (start),
        .idle      (idle),
        .dram_addr (dram_addr),
        .dram_dout (dram_dout),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .m_data    (m_data),
        .done      (done),
        .err       (err)
    );

    task automatic rand_dram();
        for (int i = 0; i < 16; i++) dram[i] = 8'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Streams ws into the loader; every handshake must write ws[i] at address i that same cycle.
    task automatic load_words(input logic [15:0] ws[$], input bit mark_last, input int gap_max);
        int g;
        for (int i = 0; i < ws.size(); i++) begin
            g = int'($urandom_range(gap_max, 0));
            repeat (g) begin
                @(negedge clk);
                s_valid = 1'b0; s_data = 16'($urandom);
                #1;
                n_vec++;
                if (iram_write !== 1'b0) begin
                    n_err++;
                    $display("FAIL load_gap: iram_write=%b want 0", iram_write);
                end
            end
            @(negedge clk);
            s_valid = 1'b1; s_data = ws[i]; s_last = mark_last && (i == ws.size() - 1);
            #1;
            n_vec++;
            if ({s_ready, iram_write, iram_addr, iram_din} !== {1'b1, 1'b1, WA'(i), ws[i]}) begin
                n_err++;
                $display("FAIL load_write[%0d]: rdy=%b we=%b addr=%0d din=%h want 1 1 %0d %h",
                         i, s_ready, iram_write, iram_addr, iram_din, i, ws[i]);
            end
        end
    endtask

    // START cycle then first RUN cycle; an extra word is offered and must be refused.
    task automatic after_load_start(input bit exp_err);
        @(negedge clk);
        s_valid = 1'b1; s_last = 1'b0; s_data = 16'($urandom);
        #1;
        n_vec++;
        if ({start, s_ready, iram_write, err} !== {1'b1, 1'b0, 1'b0, exp_err}) begin
            n_err++;
            $display("FAIL start_cycle: start=%b rdy=%b we=%b err=%b want 1 0 0 %b",
                     start, s_ready, iram_write, err, exp_err);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if ({start, s_ready, iram_write, m_valid} !== 4'b0000) begin
            n_err++;
            $display("FAIL start_pulse: start=%b rdy=%b we=%b mv=%b want 0 0 0 0",
                     start, s_ready, iram_write, m_valid);
        end
    endtask

    // Expects the LEN words dram[(BASE+i) mod 16] with random stalls, then a held DONE.
    task automatic dump_check();
        int       waitc;
        int       stalls;
        logic [7:0] e;
        bit       lst;
        for (int i = 0; i < LEN; i++) begin
            e = dram[(BASE + i) % 16];
            lst = (i == LEN - 1);
            waitc = 0;
            while (m_valid !== 1'b1 && waitc < 40) begin
                @(negedge clk);
                m_ready = 1'b0;
                #1;
                waitc++;
            end
            n_vec++;
            if ({m_valid, m_data, m_last} !== {1'b1, e, lst}) begin
                n_err++;
                $display("FAIL dump_word[%0d]: mv=%b data=%h last=%b want 1 %h %b",
                         i, m_valid, m_data, m_last, e, lst);
            end
            stalls = int'($urandom_range(3, 0));
            repeat (stalls) begin
                @(negedge clk);
                m_ready = 1'b0;
                #1;
                n_vec++;
                if ({m_valid, m_data, m_last} !== {1'b1, e, lst}) begin
                    n_err++;
                    $display("FAIL dump_stall[%0d]: mv=%b data=%h last=%b want 1 %h %b",
                             i, m_valid, m_data, m_last, e, lst);
                end
            end
            @(negedge clk);
            m_ready = 1'b1;
            #1;
            n_vec++;
            if ({m_valid, m_data, m_last} !== {1'b1, e, lst}) begin
                n_err++;
                $display("FAIL dump_hs[%0d]: mv=%b data=%h last=%b want 1 %h %b",
                         i, m_valid, m_data, m_last, e, lst);
            end
            // m_ready stays high here: it must be ignored while the next word is being read.
            @(negedge clk);
            #1;
            n_vec++;
            if ({m_valid, m_last, done} !== {1'b0, 1'b0, lst}) begin
                n_err++;
                $display("FAIL dump_after_hs[%0d]: mv=%b last=%b done=%b want 0 0 %b",
                         i, m_valid, m_last, done, lst);
            end
        end
        repeat (3) begin
            @(negedge clk);
            s_valid = 1'b1; m_ready = 1'b1;
            #1;
            n_vec++;
            if ({done, s_ready, iram_write, m_valid, start} !== 5'b10000) begin
                n_err++;
                $display("FAIL done_hold: done=%b rdy=%b we=%b mv=%b start=%b want 1 0 0 0 0",
                         done, s_ready, iram_write, m_valid, start);
            end
        end
        m_ready = 1'b0; s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b1; m_ready = 1'b1; idle = 1'b1; s_data = 16'hbeef;
        @(negedge clk);
        #1;
        n_vec++;
        if ({s_ready, iram_write, start, m_valid, m_last, done, err, iram_addr, iram_din,
             dram_addr, m_data} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: rdy=%b we=%b st=%b mv=%b ml=%b dn=%b er=%b want all 0",
                     s_ready, iram_write, start, m_valid, m_last, done, err);
        end
        @(negedge clk);
        rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        #1;
        n_vec++;
        if ({s_ready, done, err, iram_addr} !== {1'b1, 1'b0, 1'b0, WA'(0)}) begin
            n_err++;
            $display("FAIL reset_release: rdy=%b done=%b err=%b addr=%0d want 1 0 0 0",
                     s_ready, done, err, iram_addr);
        end
    endtask

    task automatic test_load_basic();
        logic [15:0] ws[$];
        ws = '{16'h0101, 16'h0202, 16'h0000};
        dram[14] = 8'd1; dram[15] = 8'd2; dram[0] = 8'd3; dram[1] = 8'd4;
        do_reset();
        idle = 1'b1;
        load_words(ws, 1'b1, 0);
        after_load_start(1'b0);
        // idle high throughout: two RUN cycles, two DUMP_RD cycles, then DUMP_OUT.
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (m_valid !== (k == 5)) begin
                n_err++;
                $display("FAIL run_idle_latency k=%0d: m_valid=%b want %b", k, m_valid, k == 5);
            end
        end
        dump_check();
    endtask

    task automatic test_overflow();
        logic [15:0] ws[$];
        for (int i = 0; i < 16; i++) ws.push_back(16'($urandom));
        rand_dram();
        do_reset();
        idle = 1'b1;
        load_words(ws, 1'b0, 2);
        after_load_start(1'b1);
        dump_check();
        n_vec++;
        if (err !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_err_sticky: err=%b want 1", err);
        end
    endtask

`ifdef PROG_LOADER_TIMEOUT_EN
    task automatic test_timeout();
        logic [15:0] ws[$];
        ws = '{16'($urandom)};
        rand_dram();
        do_reset();
        idle = 1'b0;
        load_words(ws, 1'b1, 0);
        after_load_start(1'b0);
        // RUN entry is cycle 1; after TO RUN cycles DUMP_RD begins, DUMP_OUT two cycles later.
        for (int k = 2; k <= 13; k++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if ({err, m_valid} !== {k >= 11, k == 13}) begin
                n_err++;
                $display("FAIL timeout k=%0d: err=%b mv=%b want %b %b",
                         k, err, m_valid, k >= 11, k == 13);
            end
        end
        dump_check();
    endtask
`else
    task automatic test_no_timeout();
        logic [15:0] ws[$];
        ws = '{16'($urandom), 16'($urandom)};
        rand_dram();
        do_reset();
        idle = 1'b0;
        load_words(ws, 1'b1, 1);
        after_load_start(1'b0);
        repeat (40) @(negedge clk);
        #1;
        n_vec++;
        if ({err, m_valid, done} !== 3'b000) begin
            n_err++;
            $display("FAIL run_wait: err=%b mv=%b done=%b want 0 0 0", err, m_valid, done);
        end
        idle = 1'b1;
        dump_check();
    endtask
`endif

    task automatic test_reset_mid_dump();
        logic [15:0] ws[$];
        int waitc;
        ws = '{16'($urandom), 16'($urandom)};
        rand_dram();
        do_reset();
        idle = 1'b1;
        load_words(ws, 1'b1, 0);
        after_load_start(1'b0);
        waitc = 0;
        while (m_valid !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            m_ready = 1'b0;
            #1;
            waitc++;
        end
        n_vec++;
        if (m_valid !== 1'b1) begin
            n_err++;
            $display("FAIL mid_dump_reach: m_valid=%b want 1", m_valid);
        end
        @(negedge clk);
        rst = 1'b1; m_ready = 1'b1; s_valid = 1'b1;
        #1;
        n_vec++;
        if ({m_valid, done, s_ready, iram_write, m_last} !== 5'b00000) begin
            n_err++;
            $display("FAIL mid_dump_rst: mv=%b done=%b rdy=%b we=%b ml=%b want 0 0 0 0 0",
                     m_valid, done, s_ready, iram_write, m_last);
        end
        @(negedge clk);
        rst = 1'b0; m_ready = 1'b0; s_valid = 1'b0;
        #1;
        n_vec++;
        if ({m_valid, done, s_ready, err, iram_addr} !== {4'b0010, WA'(0)}) begin
            n_err++;
            $display("FAIL mid_dump_after: mv=%b done=%b rdy=%b err=%b addr=%0d want 0 0 1 0 0",
                     m_valid, done, s_ready, err, iram_addr);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ws[$];
        int n;
        for (int rep = 0; rep < 3; rep++) begin
            do_reset();
            if (rep == 1) begin
                // Abort a partial load; the next program must start again at address 0.
                ws = '{16'($urandom), 16'($urandom), 16'($urandom)};
                load_words(ws, 1'b0, 1);
                do_reset();
            end
            rand_dram();
            idle = 1'b1;
            ws = {};
            n = int'($urandom_range(8, 1));
            for (int i = 0; i < n; i++) ws.push_back(16'($urandom));
            load_words(ws, 1'b1, 2);
            after_load_start(1'b0);
            dump_check();
        end
    endtask

    initial begin
        rand_dram();
        test_reset();
        test_load_basic();
        test_overflow();
`ifdef PROG_LOADER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_dump();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameters SHALL be (name, default, meaning): W_IDATA, 16, instruction word width; W_DDATA, 8, data word width; W_ADDR, 8, IRAM/DRAM address width; DUMP_BASE, 0, first DRAM address dumped; DUMP_LEN, 256, number of DRAM words dumped (1..2^W_ADDR); TIMEOUT, 65535, RUN cycle limit.
REQ-002 Ports SHALL be (name, direction, width, meaning): clk, in, 1, single clock. One clock; reset is synchronous and active-high.
REQ-003 rst, in, 1, synchronous active-high reset.
REQ-004 s_valid / s_ready / s_last, in / out / in, 1 each, program input stream handshake.
REQ-005 s_data, in, W_IDATA, instruction word.
REQ-006 iram_write, out, 1, IRAM write enable; iram_addr, out, W_ADDR; iram_din, out, W_IDATA.
REQ-007 start, out, 1, CPU start pulse; idle, in, 1, CPU idle status.
REQ-008 dram_addr, out, W_ADDR, DRAM read address; dram_dout, in, W_DDATA, DRAM read data with fixed 1-cycle latency.
REQ-009 m_valid / m_ready / m_last, out / in / out, 1 each, dump output stream handshake; m_data, out, W_DDATA.
REQ-010 done, out, 1, sequence complete; err, out, 1, sticky error flag.

Function
REQ-011 FSM states SHALL be LOAD, START, RUN, DUMP_RD, DUMP_OUT, DONE.
REQ-012 LOAD: s_ready=1. Each s_valid&&s_ready cycle SHALL drive iram_write=1, iram_din=s_data and iram_addr=load counter in that same cycle; the counter then increments.
REQ-013 LOAD SHALL exit to START after the handshake with s_last=1.
REQ-014 A handshake at address 2^W_ADDR-1 with s_last=0 SHALL be written, SHALL set err, and SHALL exit to START. No further input words are accepted (s_ready=0).
REQ-015 START SHALL assert start for exactly one cycle, then go to RUN.
REQ-016 RUN SHALL ignore idle in its first cycle. From its second cycle onward, idle=1 SHALL move the FSM to DUMP_RD.
REQ-017 DUMP_RD SHALL drive dram_addr=DUMP_BASE+dump counter (mod 2^W_ADDR), wait one cycle, then register dram_dout into m_data and go to DUMP_OUT.
REQ-018 DUMP_OUT: m_valid=1. m_data and m_last SHALL hold stable until m_ready=1.
REQ-019 m_last SHALL be 1 only on dump word DUMP_LEN-1.
REQ-020 On a DUMP_OUT handshake: the last word goes to DONE; otherwise the dump counter increments and the FSM returns to DUMP_RD. Throughput SHALL be at most 1 word per 2 cycles.
REQ-021 DONE: done=1, all other strobes 0, held until rst.
REQ-022 s_valid SHALL be ignored outside LOAD. m_ready SHALL be ignored outside DUMP_OUT.

Reset
REQ-023 While rst=1 sampled at a clk edge: state=LOAD; counters=0; err=0. All outputs (s_ready, iram_write, start, m_valid, m_last, done) SHALL be 0, and addresses/data 0.
REQ-024 rst asserted in any state, mid-load or mid-dump included, SHALL abort the sequence. No write or handshake SHALL occur in the cycle rst is high.

Configuration
REQ-025 With macro PROG_LOADER_TIMEOUT_EN defined, a RUN cycle counter SHALL start from 0 on RUN entry. If it reaches TIMEOUT without a qualifying idle, it SHALL set err and move to DUMP_RD anyway.
REQ-026 Without PROG_LOADER_TIMEOUT_EN, no counter is built, RUN waits indefinitely for idle, and err is set only by REQ-014.

Verification
REQ-027 Stream 3 words 0x0101, 0x0202, 0x0000 (last on word 3) -> IRAM[0..2] written in consecutive handshake cycles; start pulses 1 cycle; err=0.
REQ-028 With idle held 1 throughout -> idle is not accepted in the first RUN cycle; DUMP_RD is entered no earlier than the second RUN cycle.
REQ-029 DUMP_BASE=0xFE, DUMP_LEN=4, DRAM[0xFE,0xFF,0x00,0x01]=1,2,3,4, m_ready toggled randomly -> m_data sequence 1,2,3,4; m_last only on 4; data stable while stalled; done=1.
REQ-030 W_ADDR=4, 16 words with no s_last -> all 16 written, err=1, 17th word not accepted (s_ready=0).
REQ-031 PROG_LOADER_TIMEOUT_EN defined, TIMEOUT=10, idle held 0 -> err=1 and dump begins 10 cycles after RUN entry.
REQ-032 rst pulsed during DUMP_OUT with m_valid=1 -> next cycle m_valid=0, done=0, state LOAD, s_ready=1.
